pipe_hazard_ctrl: RTL and testbench

- Central stall/bubble generator for the 5-stage RISC-V pipeline.
- Drives the hold and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Detects load-use hazards, taken branches and data-memory wait states; tracks multi-cycle memory stalls with an FSM and a timeout counter.
- Sits in the datapath top, between the stage pipeline registers and the data-memory handshake.

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble generator for the 5-stage pipeline.
// Drives hold/clear of IF/ID, ID/EX, EX/MEM, MEM/WB and the PC. Handles
// load-use hazards, taken-branch flushes and multi-cycle data-memory waits
// with a timeout that parks the pipeline in a sticky error state.
// Optional statistics counters: define PIPE_HAZARD_CTRL_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_bubble,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use_s;
  logic mem_stall_s;
  logic hold_all_s;   // freeze everything up to MEM, bubble into WB
  logic flush_s;      // squash the two wrong-path instructions
  logic lu_stall_s;   // hold PC/IF-ID, insert one bubble into EX

  // Raw hazard conditions from the current stage contents.
  always_comb begin
    load_use_s  = ex_memread && (ex_rd != {REG_W{1'b0}}) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
    mem_stall_s = dmem_req && !dmem_ready;
  end

  // Next-state logic and stall classification; mem stall > flush > load-use.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    hold_all_s    = 1'b0;
    flush_s       = 1'b0;
    lu_stall_s    = 1'b0;
    if (reset) begin
      // Outputs stay quiet while reset is high; registers clear in the flop block.
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall_s) begin
            hold_all_s = 1'b1;
            wait_cnt_d = WC_W'(1);
            state_d    = ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            flush_s = 1'b1;
          end else if (load_use_s) begin
            lu_stall_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_stall_s) begin
            hold_all_s = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
              mem_timeout_d = 1'b1;
              state_d       = ST_ERR;
            end else begin
              wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
          end else begin
            // Release cycle (ready, or request withdrawn): EX was held, so a
            // pending branch or load-use is evaluated exactly as in RUN.
            wait_cnt_d = {WC_W{1'b0}};
            state_d    = ST_RUN;
            if (ex_branch_taken) begin
              flush_s = 1'b1;
            end else if (load_use_s) begin
              lu_stall_s = 1'b1;
            end else begin
              lu_stall_s = 1'b0;
            end
          end
        end
        ST_ERR: begin
          hold_all_s = 1'b1;
        end
        default: begin
          state_d    = ST_RUN;
          wait_cnt_d = {WC_W{1'b0}};
        end
      endcase
    end
  end

  // Map the stall class onto register controls; hold and bubble never overlap.
  always_comb begin
    pc_hold      = hold_all_s | lu_stall_s;
    ifid_hold    = hold_all_s | lu_stall_s;
    ifid_bubble  = flush_s;
    idex_hold    = hold_all_s;
    idex_bubble  = flush_s | lu_stall_s;
    exmem_hold   = hold_all_s;
    memwb_bubble = hold_all_s;
    mem_timeout  = mem_timeout_q;
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= {WC_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Free-running wrap-around statistics.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_hold) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush_s) begin
      flush_events_d = flush_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= {CNT_W{1'b0}};
      flush_events_q <= {CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT=4). A behavioural model
// counts consecutive wait cycles and tracks the error latch; directed steps
// are followed by biased random traffic.
module tb_pipe_hazard_ctrl;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  // Control vector order: pc_hold, ifid_hold, ifid_bubble, idex_hold,
  // idex_bubble, exmem_hold, memwb_bubble
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100100;
  localparam logic [6:0] C_FLUSH = 7'b0010100;
  localparam logic [6:0] C_HOLD  = 7'b1101011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
  logic             dmem_req, dmem_ready;
  logic             pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble;
  logic             exmem_hold, memwb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_bubble(ifid_bubble),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_waits;
  bit               m_err;
  bit               m_timeout;
  logic [CNT_W-1:0] m_stalls;
  logic [CNT_W-1:0] m_flushes;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model.
  task automatic do_cycle(input string tag);
    logic [6:0] exp;
    bit lu;
    bit fl;
    @(negedge clk);
    lu = ex_memread && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    fl  = 1'b0;
    exp = C_NONE;
    chk({tag, "_timeout"}, {63'd0, mem_timeout}, {63'd0, m_timeout});
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk({tag, "_stalls"}, {32'd0, stall_cycles}, {32'd0, m_stalls});
    chk({tag, "_flushes"}, {32'd0, flush_events}, {32'd0, m_flushes});
`else
    chk({tag, "_stalls"}, {32'd0, stall_cycles}, 64'd0);
    chk({tag, "_flushes"}, {32'd0, flush_events}, 64'd0);
`endif
    if (reset) begin
      exp = C_NONE;
    end else if (m_err) begin
      exp = C_HOLD;
    end else if (dmem_req && !dmem_ready) begin
      exp = C_HOLD;
      m_waits++;
      if (m_waits == TIMEOUT) begin
        m_err     = 1'b1;
        m_timeout = 1'b1;
      end
    end else begin
      m_waits = 0;
      if (ex_branch_taken) begin
        exp = C_FLUSH;
        fl  = 1'b1;
      end else if (lu) begin
        exp = C_LU;
      end
    end
    chk({tag, "_ctrl"},
        {57'd0, pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble, exmem_hold, memwb_bubble},
        {57'd0, exp});
    if (reset) begin
      m_waits = 0; m_err = 1'b0; m_timeout = 1'b0;
      m_stalls = '0; m_flushes = '0;
    end else begin
      if (exp[6]) m_stalls = m_stalls + 1;
      if (fl) m_flushes = m_flushes + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_waits = 0; m_err = 1'b0; m_timeout = 1'b0; m_stalls = '0; m_flushes = '0;
    set_idle();
    reset = 1'b1;
    do_cycle("reset0");
    do_cycle("reset1");
    reset = 1'b0;
    do_cycle("idle");

    // Load-use on rs1, then hazard gone
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    do_cycle("loaduse");
    ex_memread = 1'b0;
    do_cycle("loaduse_clear");

    // Load-use on rs2
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; id_use_rs1 = 1'b0;
    do_cycle("loaduse_rs2");

    // Load to x0 never stalls
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    do_cycle("load_x0");

    // Branch with coincident load-use
    ex_rd = 5'd7; id_rs1 = 5'd7; ex_branch_taken = 1'b1;
    do_cycle("branch_lu");
    set_idle();
    do_cycle("after_branch");

    // Three wait cycles, then ready
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) do_cycle("memwait");
    dmem_ready = 1'b1;
    do_cycle("mem_release");
    set_idle();
    do_cycle("post_release");

    // Withdrawn request during wait releases too; pending branch re-presented
    dmem_req = 1'b1; dmem_ready = 1'b0;
    do_cycle("wd_wait");
    dmem_req = 1'b0; ex_branch_taken = 1'b1;
    do_cycle("wd_release_branch");
    set_idle();

    // Timeout into ERR, then ERR persists even with ready
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (TIMEOUT) do_cycle("timeout_wait");
    dmem_ready = 1'b1;
    repeat (3) do_cycle("err_hold");
    set_idle();
    do_cycle("err_idle");
    reset = 1'b1;
    do_cycle("err_reset");
    reset = 1'b0;
    do_cycle("after_err_reset");

    // Reset on the second wait cycle
    dmem_req = 1'b1; dmem_ready = 1'b0;
    do_cycle("rst_wait1");
    reset = 1'b1;
    do_cycle("rst_wait2");
    reset = 1'b0; dmem_req = 1'b0;
    do_cycle("rst_after");
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    do_cycle("rst_run_lu");
    set_idle();

    // Biased random traffic
    for (int i = 0; i < 500; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_rs1          = REG_W'($urandom_range(0, 3));
      id_rs2          = REG_W'($urandom_range(0, 3));
      ex_rd           = REG_W'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      dmem_req        = 1'($urandom_range(0, 1));
      dmem_ready      = ($urandom_range(0, 9) > 3);
      do_cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
